// File: rtl/events_rate_pkg.sv
// Shared types and defaults for the events-rate counter and its reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package events_rate_pkg;

  // Defaults shared with the counter block so both ends agree on widths.
  localparam int COUNTER_LENGTH_DEF = 24;
  localparam int CHANNEL_NUMBER_DEF = 2;
  localparam int SEQ_WIDTH_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    LATCH,
    SEND
  } state_t;

  // Channel index field width; never narrower than one bit.
  function automatic int ch_idx_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  localparam int CH_IDX_WIDTH_DEF = ch_idx_width(CHANNEL_NUMBER_DEF);

  // One stream word at the default widths: sequence number in the MSBs.
  typedef struct packed {
    logic [SEQ_WIDTH_DEF-1:0]      seq;
    logic [CH_IDX_WIDTH_DEF-1:0]   ch_idx;
    logic [COUNTER_LENGTH_DEF-1:0] count;
  } word_t;

endpackage

// File: rtl/events_rate_reader.sv
// Reads per-window channel counts from the rate counter and streams them as one word per channel.
// Latency: read pulse -> snapshot 1 cycle later -> first word valid on the following cycle.
// Backpressure: words hold while m_ready is low; a window finishing mid-packet stretches and flags overrun.
module events_rate_reader
  import events_rate_pkg::*;
#(
  parameter int  COUNTER_LENGTH = COUNTER_LENGTH_DEF,
  parameter int  CHANNEL_NUMBER = CHANNEL_NUMBER_DEF,
  parameter int  SEQ_WIDTH      = SEQ_WIDTH_DEF,
  localparam int CH_IDX_WIDTH   = ch_idx_width(CHANNEL_NUMBER),
  localparam int DATA_WIDTH     = SEQ_WIDTH + CH_IDX_WIDTH + COUNTER_LENGTH
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic                                          events_rate_ready,
  input  logic [CHANNEL_NUMBER-1:0][COUNTER_LENGTH-1:0] event_count,
  output logic                                          read,
  output logic                                          clear,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [DATA_WIDTH-1:0]                         m_data,
  output logic                                          m_last,
  output logic                                          overrun,
  output logic                                          busy
);

  localparam logic [CH_IDX_WIDTH-1:0] LAST_IDX = CH_IDX_WIDTH'(CHANNEL_NUMBER - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [SEQ_WIDTH-1:0]      seq;
  logic [CH_IDX_WIDTH-1:0]   idx;
  logic [COUNTER_LENGTH-1:0] snapshot [CHANNEL_NUMBER];
  logic                      word_last;

  assign word_last = (idx == LAST_IDX);

  // State register; reset parks the reader in IDLE with every strobe low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus all outputs decoded from the current state, so reset clears them without a clock.
  always_comb begin
    state_nxt = state;
    read      = 1'b0;
    clear     = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) state_nxt = CLEAR;
      end
      CLEAR: begin
        clear     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (events_rate_ready) begin
          read      = 1'b1;
          state_nxt = LATCH;
        end
      end
      // Counts appear on event_count during this cycle; ready is dropping and is ignored.
      LATCH: state_nxt = SEND;
      SEND: begin
        m_valid = 1'b1;
        m_last  = word_last;
        m_data  = {seq, idx, snapshot[idx]};
        if (m_ready && word_last) state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet sequence number, word index and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq     <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          seq     <= '0;
          overrun <= 1'b0;
        end
        LATCH: idx <= '0;
        SEND: begin
          // A window closed before the previous packet drained; it keeps counting until the next read.
          if (events_rate_ready) overrun <= 1'b1;
          if (m_ready) begin
            if (word_last) seq <= seq + 1'b1;
            else           idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Snapshot every channel count at the end of LATCH; copied unmodified.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) snapshot[i] <= '0;
    end else if (state == LATCH) begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) snapshot[i] <= event_count[i];
    end
  end

endmodule

// File: tb/tb_events_rate_reader.sv
// Bench for events_rate_reader: directed vector table, then a counter model with random events and backpressure.
// Latency: n/a.
// Backpressure: m_ready driven from the table, randomly, or held low for the stall cases.
module tb_events_rate_reader;
  import events_rate_pkg::*;

  localparam int CL  = 24;
  localparam int CN  = 2;
  localparam int SW  = 8;
  localparam int CW  = ch_idx_width(CN);
  localparam int DW  = SW + CW + CL;
  localparam int CTV = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic m_ready = 1'b0;
  logic events_rate_ready;
  logic [CN-1:0][CL-1:0] event_count;
  logic read, clear, m_valid, m_last, overrun, busy;
  logic [DW-1:0] m_data;

  int checks = 0;
  int failures = 0;

  // Stimulus source select: table-driven inputs or the counter model.
  logic use_ctr = 1'b0;
  logic rand_mr = 1'b0;
  logic t_rdy = 1'b0;
  logic [CL-1:0] t_c0 = '0, t_c1 = '0;

  logic [CL-1:0] acc0, acc1, out0, out1;
  logic ctr_ready;
  int timer;

  assign events_rate_ready = use_ctr ? ctr_ready : t_rdy;
  assign event_count       = use_ctr ? {out1, out0} : {t_c1, t_c0};

  events_rate_reader #(.COUNTER_LENGTH(CL), .CHANNEL_NUMBER(CN), .SEQ_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .events_rate_ready(events_rate_ready),
    .event_count(event_count), .read(read), .clear(clear), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int s, input int i, input int c);
    word_t w;
    w.seq    = SW'(s);
    w.ch_idx = CW'(i);
    w.count  = CL'(c);
    return w;
  endfunction

  // Counter block model: window of CTV cycles, ready held until read, counts keep accumulating meanwhile.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= 0; acc0 <= '0; acc1 <= '0; out0 <= '0; out1 <= '0; ctr_ready <= 1'b0;
    end else if (clear) begin
      timer <= 0; acc0 <= '0; acc1 <= '0; ctr_ready <= 1'b0;
    end else if (read) begin
      out0 <= acc0; out1 <= acc1;
      acc0 <= CL'($urandom_range(0, 1));
      acc1 <= CL'($urandom_range(0, 3));
      timer <= 0; ctr_ready <= 1'b0;
    end else begin
      acc0 <= acc0 + CL'($urandom_range(0, 1));
      acc1 <= acc1 + CL'($urandom_range(0, 3));
      if (!ctr_ready) begin
        if (timer == CTV - 1) ctr_ready <= 1'b1;
        else                  timer <= timer + 1;
      end
    end
  end

  // Random downstream acceptance when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_mr) m_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: each read queues a packet of the counts accumulated so far, numbered modulo 256 since the last clear.
  typedef struct { int seq; int c0; int c1; } pkt_t;
  pkt_t q[$];
  int seq_m = 0, widx = 0, pkts = 0, last_seq = -1;
  bit wrap_seen = 0, prev_stall = 0, prev_clear = 0;
  logic [DW-1:0] prev_data, exp_w;

  always @(negedge clk) begin
    if (reset) begin
      q.delete(); widx = 0; seq_m = 0; last_seq = -1; prev_stall = 0; prev_clear = 0;
    end else if (use_ctr) begin
      if (read || clear) check("read_clear_exclusive", 64'(read && clear), 0);
      if (clear) begin
        check("clear_single_cycle", 64'(prev_clear), 0);
        seq_m = 0; last_seq = -1;
      end
      if (read) begin
        check("no_read_in_send", 64'(m_valid), 0);
        q.push_back('{seq_m % 256, int'(acc0), int'(acc1)});
        seq_m++;
      end
      if (prev_stall) begin
        check("stall_valid_held", 64'(m_valid), 1);
        check("stall_data_held", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=%0h expected=none", m_data);
        end else begin
          exp_w = mk(q[0].seq, widx, (widx == 0) ? q[0].c0 : q[0].c1);
          check("word_data", 64'(m_data), 64'(exp_w));
          check("word_last", 64'(m_last), 64'(widx == CN - 1));
          if (widx == CN - 1) begin
            if (last_seq == 255 && q[0].seq == 0) wrap_seen = 1;
            last_seq = q[0].seq;
            void'(q.pop_front());
            widx = 0;
            pkts++;
          end else begin
            widx++;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_clear = clear;
    end
  end

  task automatic set_en(input logic v);
    @(posedge clk); #1 enable = v;
  endtask

  task automatic set_mr(input logic v);
    @(posedge clk); #1 rand_mr = 1'b0; m_ready = v;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < budget);
    check("wait_valid", 64'(m_valid), 1);
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int target = pkts + n;
    int c = 0;
    while (pkts < target && c < budget) begin @(negedge clk); c++; end
    check("packets_done", 64'(pkts >= target), 1);
  endtask

  task automatic wait_clear(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (clear) begin got = 1; break; end
    end
    check("clear_after_enable", 64'(got), 1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    do begin @(negedge clk); c++; end while (busy && c < budget);
    check("reached_idle", 64'(busy), 0);
  endtask

  typedef struct {
    logic en; logic rdy; int c0; int c1; logic mr;
    logic [5:0] ctl;          // {read, clear, m_valid, m_last, busy, overrun}
    logic [DW-1:0] data;
  } vec_t;
  vec_t tv[12];

  initial begin
    int nreads;
    tv[0]  = '{1'b0, 1'b0,   0,   0, 1'b0, 6'b000000, mk(0, 0, 0)};
    tv[1]  = '{1'b1, 1'b0,   0,   0, 1'b0, 6'b000000, mk(0, 0, 0)};
    tv[2]  = '{1'b1, 1'b0,   0,   0, 1'b0, 6'b010010, mk(0, 0, 0)};
    tv[3]  = '{1'b1, 1'b0,   0,   0, 1'b0, 6'b000010, mk(0, 0, 0)};
    tv[4]  = '{1'b1, 1'b1,  77,  88, 1'b0, 6'b100010, mk(0, 0, 0)};
    tv[5]  = '{1'b1, 1'b1,   5,   9, 1'b0, 6'b000010, mk(0, 0, 0)};
    tv[6]  = '{1'b1, 1'b0, 111, 222, 1'b0, 6'b001010, mk(0, 0, 5)};
    tv[7]  = '{1'b1, 1'b0, 111, 222, 1'b1, 6'b001010, mk(0, 0, 5)};
    tv[8]  = '{1'b0, 1'b0, 111, 222, 1'b0, 6'b001110, mk(0, 1, 9)};
    tv[9]  = '{1'b0, 1'b0, 111, 222, 1'b1, 6'b001110, mk(0, 1, 9)};
    tv[10] = '{1'b0, 1'b1,   0,   0, 1'b0, 6'b000010, mk(0, 0, 0)};
    tv[11] = '{1'b0, 1'b1,   0,   0, 1'b0, 6'b000000, mk(0, 0, 0)};

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({read, clear, m_valid, m_last, busy, overrun}), 0);
    check("reset_data", 64'(m_data), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Directed walk: clear, read, latch, two words with backpressure, enable drop mid-packet.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      enable = tv[i].en; t_rdy = tv[i].rdy;
      t_c0 = CL'(tv[i].c0); t_c1 = CL'(tv[i].c1); m_ready = tv[i].mr;
      #1;
      check($sformatf("vec%0d_ctl", i), 64'({read, clear, m_valid, m_last, busy, overrun}), 64'(tv[i].ctl));
      if (tv[i].ctl[3]) check($sformatf("vec%0d_data", i), 64'(m_data), 64'(tv[i].data));
    end

    // Counter model with random events and random acceptance.
    @(posedge clk); #1 use_ctr = 1'b1; t_rdy = 1'b0; m_ready = 1'b0; rand_mr = 1'b1; enable = 1'b1;
    wait_pkts(8, 2000);
    @(negedge clk); check("overrun_quiet", 64'(overrun), 0);

    // Overrun: stall the first word past a full window.
    set_mr(1'b0);
    wait_valid(200);
    repeat (30) @(negedge clk);
    check("overrun_set", 64'(overrun), 1);
    @(posedge clk); #1 rand_mr = 1'b1;
    wait_pkts(3, 500);
    @(negedge clk); check("overrun_sticky", 64'(overrun), 1);

    // Enable toggle discards state: overrun and seq restart after the clear.
    set_en(1'b0);
    wait_idle(300);
    set_en(1'b1);
    wait_clear(10);
    @(negedge clk); check("overrun_cleared", 64'(overrun), 0);
    wait_pkts(2, 500);

    // Sequence wrap over 256.
    wait_pkts(258, 258 * 80);
    check("seq_wrap_seen", 64'(wrap_seen), 1);

    // Enable dropped mid-packet: remaining words still go out, then idle with no reads.
    set_mr(1'b0);
    wait_valid(200);
    set_en(1'b0);
    repeat (3) @(negedge clk);
    set_mr(1'b1);
    wait_idle(50);
    check("no_partial_packet", 64'(q.size() + widx), 0);
    nreads = 0;
    repeat (40) begin @(negedge clk); if (read) nreads++; end
    check("no_read_while_idle", 64'(nreads), 0);
    check("idle_not_busy", 64'(busy), 0);
    set_en(1'b1);
    wait_clear(10);
    @(posedge clk); #1 rand_mr = 1'b1;
    wait_pkts(2, 500);

    // Asynchronous reset between edges while a packet is stalled with overrun set.
    set_mr(1'b0);
    wait_valid(200);
    repeat (30) @(negedge clk);
    check("overrun_before_reset", 64'(overrun), 1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("async_reset_outputs", 64'({m_valid, read, clear, overrun, busy}), 0);
    check("async_reset_data", 64'(m_data), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    wait_clear(5);
    @(posedge clk); #1 rand_mr = 1'b1;
    wait_pkts(3, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
